vcmd_stream: RTL and testbench

- Parametrised successor to the fixed single-pixel command decoder.
- Sits between the SPI byte receiver, after its DataRecv strobe is synchronised into the system clock domain, and the frame-buffer write port.
- Parses command packets into memory write transactions. Supports single write, auto-incrementing burst write and (optionally) hardware fill.
- Uses a valid/ack handshake toward memory and reports errors through sticky flags.

---
 rtl/vcmd_stream.sv | 203 ++++++++++++++++++++
 tb/tb_vcmd_stream.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vcmd_stream.sv
// Command-packet decoder turning SPI bytes into frame-buffer writes (single, burst, fill).
// Define VCMD_FILL_EN to build the hardware fill opcode; otherwise opcode 11 is flagged illegal.
module vcmd_stream #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_LEN_W = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CmdRecv,
  input  logic [7:0]        CmdIn,
  input  logic              CmdAbort,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataRdy,
  input  logic              MemAck,
  output logic              Busy,
  output logic              ErrOverrun,
  output logic              ErrIllegal
);

  localparam int unsigned ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int unsigned DATA_BYTES = DATA_W / 8;
  localparam int unsigned MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned CNT_W      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_BURST = 2'b10;

`ifdef VCMD_FILL_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, FILLDATA, FILL} stateT;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} stateT;
`endif

  stateT                state;
  logic [CNT_W-1:0]     byteCnt;
  logic [DATA_W-1:0]    dataAsm;
  logic [ADDR_W-1:0]    wordAddr;
  logic [MAX_LEN_W-1:0] wordsLeft;
`ifdef VCMD_FILL_EN
  logic                 fillMode;
  logic [DATA_W-1:0]    fillData;
`endif

  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] dataNext;
  logic              holdFree;
  logic              lastAddrByte;
  logic              lastDataByte;
  logic              lastWord;

  // Byte-wise MSB-first shift; surplus upper bits fall off the top.
  assign addrNext     = ADDR_W'({wordAddr, CmdIn});
  assign dataNext     = DATA_W'({dataAsm, CmdIn});
  // Holding register can take a new word if empty or retiring this cycle.
  assign holdFree     = !DataRdy || MemAck;
  assign lastAddrByte = (byteCnt == CNT_W'(ADDR_BYTES - 1));
  assign lastDataByte = (byteCnt == CNT_W'(DATA_BYTES - 1));
  assign lastWord     = (wordsLeft == '0);
  assign Busy         = (state != IDLE) || DataRdy;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      byteCnt    <= '0;
      dataAsm    <= '0;
      wordAddr   <= '0;
      wordsLeft  <= '0;
      MemAddr    <= '0;
      DataOut    <= '0;
      DataRdy    <= 1'b0;
      ErrOverrun <= 1'b0;
      ErrIllegal <= 1'b0;
`ifdef VCMD_FILL_EN
      fillMode   <= 1'b0;
      fillData   <= '0;
`endif
    end else begin
      if (DataRdy && MemAck) begin
        DataRdy <= 1'b0;
      end

      if (CmdAbort) begin
        // Abort wins over a simultaneous byte; a presented word still finishes its handshake.
        state    <= IDLE;
        byteCnt  <= '0;
        dataAsm  <= '0;
        wordAddr <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (CmdRecv) begin
              byteCnt   <= '0;
              dataAsm   <= '0;
              wordAddr  <= '0;
              wordsLeft <= (CmdIn[7:6] == OP_WRITE) ? '0 : MAX_LEN_W'(CmdIn[5:0]);
              case (CmdIn[7:6])
                OP_NOP: begin
                  if (CmdIn[5:0] == 6'h3F) begin
                    ErrOverrun <= 1'b0;
                    ErrIllegal <= 1'b0;
                  end
                end
                OP_WRITE, OP_BURST: begin
                  state <= ADDR;
`ifdef VCMD_FILL_EN
                  fillMode <= 1'b0;
`endif
                end
                default: begin
`ifdef VCMD_FILL_EN
                  state    <= ADDR;
                  fillMode <= 1'b1;
`else
                  ErrIllegal <= 1'b1;
`endif
                end
              endcase
            end
          end

          ADDR: begin
            if (CmdRecv) begin
              wordAddr <= addrNext;
              if (lastAddrByte) begin
                byteCnt <= '0;
`ifdef VCMD_FILL_EN
                state   <= fillMode ? FILLDATA : DATA;
`else
                state   <= DATA;
`endif
              end else begin
                byteCnt <= byteCnt + CNT_W'(1);
              end
            end
          end

          DATA: begin
            if (CmdRecv) begin
              if (lastDataByte) begin
                byteCnt <= '0;
                dataAsm <= '0;
                if (holdFree) begin
                  MemAddr <= wordAddr;
                  DataOut <= dataNext;
                  DataRdy <= 1'b1;
                end else begin
                  ErrOverrun <= 1'b1;
                end
                // Address advances even when the word was dropped.
                wordAddr  <= wordAddr + ADDR_W'(1);
                wordsLeft <= wordsLeft - MAX_LEN_W'(1);
                if (lastWord) begin
                  state <= IDLE;
                end
              end else begin
                dataAsm <= dataNext;
                byteCnt <= byteCnt + CNT_W'(1);
              end
            end
          end

`ifdef VCMD_FILL_EN
          FILLDATA: begin
            if (CmdRecv) begin
              if (lastDataByte) begin
                byteCnt  <= '0;
                dataAsm  <= '0;
                fillData <= dataNext;
                state    <= FILL;
              end else begin
                dataAsm <= dataNext;
                byteCnt <= byteCnt + CNT_W'(1);
              end
            end
          end

          FILL: begin
            if (CmdRecv) begin
              ErrOverrun <= 1'b1;
            end
            if (holdFree) begin
              MemAddr   <= wordAddr;
              DataOut   <= fillData;
              DataRdy   <= 1'b1;
              wordAddr  <= wordAddr + ADDR_W'(1);
              wordsLeft <= wordsLeft - MAX_LEN_W'(1);
              if (lastWord) begin
                state <= IDLE;
              end
            end
          end
`endif

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vcmd_stream.sv
// Directed plus randomized bench for vcmd_stream, checked against a packet-level write model.
module tb_vcmd_stream;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 8;
`ifdef VCMD_FILL_EN
  localparam bit FILL_ON = 1'b1;
`else
  localparam bit FILL_ON = 1'b0;
`endif

  logic          Clk;
  logic          Reset;
  logic          CmdRecv;
  logic [7:0]    CmdIn;
  logic          CmdAbort;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] DataOut;
  logic          DataRdy;
  logic          MemAck;
  logic          Busy;
  logic          ErrOverrun;
  logic          ErrIllegal;

  typedef logic [AW+DW-1:0] wrT;
  wrT         expQ[$];
  wrT         actQ[$];
  logic [7:0] pkt[$];
  int         nChecks = 0;
  int         nFail   = 0;
  bit         randAck = 1'b0;

  vcmd_stream #(.ADDR_W(AW), .DATA_W(DW), .MAX_LEN_W(6)) dut (
    .Clk(Clk), .Reset(Reset), .CmdRecv(CmdRecv), .CmdIn(CmdIn), .CmdAbort(CmdAbort),
    .MemAddr(MemAddr), .DataOut(DataOut), .DataRdy(DataRdy), .MemAck(MemAck),
    .Busy(Busy), .ErrOverrun(ErrOverrun), .ErrIllegal(ErrIllegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs change at posedge+1, so a negedge sample sees what the next edge will accept.
  always @(negedge Clk) begin
    if (!Reset && DataRdy && MemAck) actQ.push_back({MemAddr, DataOut});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (randAck) MemAck = 1'($urandom_range(0, 1));
  endtask

  task automatic sendByte(input logic [7:0] b);
    CmdIn   = b;
    CmdRecv = 1'b1;
    tick();
    CmdRecv = 1'b0;
  endtask

  task automatic mk(input int n, input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
    logic [7:0] t[7];
    t = '{b0, b1, b2, b3, b4, b5, b6};
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(t[i]);
  endtask

  // When paced, each data byte waits for an empty holding register so no word is dropped.
  task automatic sendPacket(input bit pace);
    for (int i = 0; i < pkt.size(); i++) begin
      if (pace && i >= 4) begin
        for (int n = 0; n < 200 && DataRdy; n++) tick();
        chk("hold drain", 32'(DataRdy), 32'd0);
      end
      sendByte(pkt[i]);
    end
  endtask

  task automatic waitIdle();
    for (int n = 0; n < 300 && Busy; n++) tick();
    chk("idle", 32'(Busy), 32'd0);
  endtask

  // Expected writes of a complete, unaborted, non-overrunning packet.
  function automatic void modelPacket();
    int unsigned     op, arg, cnt;
    longint unsigned addr, a;
    logic [7:0]      d;
    op  = int'(pkt[0]) / 64;
    arg = int'(pkt[0]) % 64;
    if (op == 1 || op == 2 || (op == 3 && FILL_ON)) begin
      addr = 0;
      for (int i = 1; i <= 3; i++) addr = addr * 256 + longint'(pkt[i]);
      addr = addr % (64'd1 << AW);
      cnt  = (op == 1) ? 1 : arg + 1;
      for (int w = 0; w < int'(cnt); w++) begin
        d = (op == 3) ? pkt[4] : pkt[4 + w];
        a = (addr + longint'(w)) % (64'd1 << AW);
        expQ.push_back({AW'(a), d});
      end
    end
  endfunction

  task automatic checkWrites(input string tag);
    int n;
    wrT ac, ex;
    chk({tag, " count"}, 32'(actQ.size()), 32'(expQ.size()));
    n = (actQ.size() < expQ.size()) ? actQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      ac = actQ[i];
      ex = expQ[i];
      chk({tag, " addr"}, 32'(ac[AW+DW-1:DW]), 32'(ex[AW+DW-1:DW]));
      chk({tag, " data"}, 32'(ac[DW-1:0]), 32'(ex[DW-1:0]));
    end
    actQ.delete();
    expQ.delete();
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, " MemAddr"}, 32'(MemAddr), 32'd0);
    chk({tag, " DataOut"}, 32'(DataOut), 32'd0);
    chk({tag, " DataRdy"}, 32'(DataRdy), 32'd0);
    chk({tag, " Busy"}, 32'(Busy), 32'd0);
    chk({tag, " ErrOverrun"}, 32'(ErrOverrun), 32'd0);
    chk({tag, " ErrIllegal"}, 32'(ErrIllegal), 32'd0);
  endtask

  initial begin
    int hi, rises;
    logic prev;
    logic [7:0] cmd;
    int nData;

    Reset = 1'b1; CmdRecv = 1'b0; CmdIn = 8'h00; CmdAbort = 1'b0; MemAck = 1'b0;
    repeat (3) tick();
    checkAllZero("reset");
    Reset = 1'b0;
    tick();

    // Single write, one-cycle DataRdy
    MemAck = 1'b1;
    mk(5, 8'h41, 8'h01, 8'h23, 8'h45, 8'hC0, 0, 0);
    sendPacket(1'b0);
    chk("single rdy", 32'(DataRdy), 32'd1);
    chk("single addr", 32'(MemAddr), 32'h12345);
    chk("single data", 32'(DataOut), 32'hC0);
    tick();
    chk("single rdy fall", 32'(DataRdy), 32'd0);
    chk("single busy", 32'(Busy), 32'd0);
    modelPacket();
    checkWrites("single");

    // Burst wrapping past the top of the address space
    mk(7, 8'h82, 8'h03, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33);
    sendPacket(1'b0);
    waitIdle();
    modelPacket();
    checkWrites("burst");

    // Opcode 11: fill or illegal depending on build
    mk(5, 8'hC3, 8'h00, 8'h00, 8'h10, 8'h55, 0, 0);
    sendPacket(1'b0);
`ifdef VCMD_FILL_EN
    hi = 0; rises = 0; prev = DataRdy;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (DataRdy) hi++;
      if (DataRdy && !prev) rises++;
      prev = DataRdy;
    end
    chk("fill rdy cycles", 32'(hi), 32'd4);
    chk("fill rdy runs", 32'(rises), 32'd1);
    waitIdle();
    modelPacket();
    checkWrites("fill");
`else
    chk("illegal flag", 32'(ErrIllegal), 32'd1);
    // The trailing 0x55 parses as a new WRITE command; drop it.
    CmdAbort = 1'b1;
    tick();
    CmdAbort = 1'b0;
    waitIdle();
    modelPacket();
    checkWrites("illegal");
    sendByte(8'h3F);
    chk("illegal clear", 32'(ErrIllegal), 32'd0);
`endif

    // Overrun with memory stalled
    MemAck = 1'b0;
    mk(6, 8'h81, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 0);
    sendPacket(1'b0);
    tick();
    chk("ovr flag", 32'(ErrOverrun), 32'd1);
    chk("ovr rdy", 32'(DataRdy), 32'd1);
    chk("ovr addr", 32'(MemAddr), 32'h100);
    chk("ovr data", 32'(DataOut), 32'hAA);
    chk("ovr busy", 32'(Busy), 32'd1);
    MemAck = 1'b1;
    waitIdle();
    expQ.push_back({18'h00100, 8'hAA});
    checkWrites("ovr");
    sendByte(8'h3F);
    chk("ovr clear", 32'(ErrOverrun), 32'd0);

    // Abort mid-address, then abort colliding with a byte
    sendByte(8'h41);
    sendByte(8'h01);
    CmdAbort = 1'b1;
    tick();
    CmdAbort = 1'b0;
    chk("abort busy", 32'(Busy), 32'd0);
    sendByte(8'h41);
    CmdIn = 8'h41; CmdRecv = 1'b1; CmdAbort = 1'b1;
    tick();
    CmdRecv = 1'b0; CmdAbort = 1'b0;
    chk("abort+byte busy", 32'(Busy), 32'd0);
    mk(5, 8'h41, 8'h00, 8'h00, 8'h07, 8'h99, 0, 0);
    sendPacket(1'b0);
    waitIdle();
    modelPacket();
    checkWrites("after abort");

    // Reset in the middle of a burst header
`ifndef VCMD_FILL_EN
    sendByte(8'hC0);
    chk("pre-reset illegal", 32'(ErrIllegal), 32'd1);
`endif
    sendByte(8'h82);
    sendByte(8'h00);
    sendByte(8'h00);
    Reset = 1'b1;
    tick();
    checkAllZero("midreset");
    Reset = 1'b0;
    mk(5, 8'h41, 8'h00, 8'h12, 8'h34, 8'h56, 0, 0);
    sendPacket(1'b0);
    waitIdle();
    modelPacket();
    checkWrites("post reset");

    // Random packets with random memory back-pressure
    randAck = 1'b1;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          sendByte(8'($urandom_range(0, 62)));
          chk("rand nop busy", 32'(Busy), 32'd0);
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            cmd   = 8'h40 | 8'($urandom_range(0, 63));
            nData = 1;
          end else begin
            cmd   = 8'h80 | 8'($urandom_range(0, 7));
            nData = int'(cmd[5:0]) + 1;
          end
          pkt.delete();
          pkt.push_back(cmd);
          for (int i = 0; i < 3 + nData; i++) pkt.push_back(8'($urandom_range(0, 255)));
          sendPacket(1'b1);
          waitIdle();
          modelPacket();
          checkWrites("rand");
          chk("rand overrun", 32'(ErrOverrun), 32'd0);
        end
      endcase
    end
    randAck = 1'b0;
    MemAck  = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
